// File: rtl/fp_norm_ctrl_pkg.sv
// Shared definitions for the post-add normalization sequencer: FSM encoding,
// Inf/NaN exponent code and the binary-search step-width table.
package fp_norm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned EXP_MAX_DEF = 255;
  localparam int unsigned N_STEPS     = 5;
  localparam logic [2:0]  LAST_STEP   = 3'd4;

  // Step widths 16/8/4/2/1 for search steps 0..4.
  function automatic logic [4:0] step_width(input logic [2:0] step);
    logic [4:0] k;
    case (step)
      3'd0:    k = 5'd16;
      3'd1:    k = 5'd8;
      3'd2:    k = 5'd4;
      3'd3:    k = 5'd2;
      default: k = 5'd1;
    endcase
    return k;
  endfunction

  // Mask selecting the top k bits of the 24-bit significand field.
  function automatic logic [23:0] top_mask(input logic [4:0] k);
    return ~(24'hFF_FFFF >> k);
  endfunction

endpackage

// File: rtl/fp_norm_ctrl_shift_left.sv
// 25-bit, 5-stage logarithmic left barrel shifter (purely combinational).
module fp_norm_ctrl_shift_left (
  input  logic [24:0] i_data,
  input  logic [4:0]  i_shift,
  output logic [24:0] o_data
);

  logic [24:0] w_s0;
  logic [24:0] w_s1;
  logic [24:0] w_s2;
  logic [24:0] w_s3;

  assign w_s0   = i_shift[0] ? {i_data[23:0], 1'b0}  : i_data;
  assign w_s1   = i_shift[1] ? {w_s0[22:0], 2'b0}    : w_s0;
  assign w_s2   = i_shift[2] ? {w_s1[20:0], 4'b0}    : w_s1;
  assign w_s3   = i_shift[3] ? {w_s2[16:0], 8'b0}    : w_s2;
  assign o_data = i_shift[4] ? {w_s3[8:0], 16'b0}    : w_s3;

endmodule

// File: rtl/fp_norm_ctrl.sv
// Iterative FP32 post-add normalizer: 5-step binary search for the left-shift
// amount, exponent clamping to denormal, carry-out, zero and Inf/NaN handling.
module fp_norm_ctrl
  import fp_norm_ctrl_pkg::*;
#(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MANT_W  = 25,
  parameter int unsigned EXP_MAX = EXP_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [23:0]       out_mant,
  output logic              out_ovf,
  output logic              out_zero,
  output logic              out_denorm
);

  localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  state_t            r_state;
  logic              r_sign;
  logic [EXP_W-1:0]  r_exp;
  logic [MANT_W-1:0] r_mant;
  logic [4:0]        r_sh;
  logic [2:0]        r_step;
  logic              r_ovf;
  logic              r_spec;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [24:0]       w_cur;
  logic [4:0]        w_k;
  logic              w_top_clear;
  logic              w_exp_gt;
  logic [EXP_W-1:0]  w_exp_inc;
  logic [EXP_W-1:0]  w_exp_dec;

  fp_norm_ctrl_shift_left u_shift_left (
    .i_data  (r_mant),
    .i_shift (r_sh),
    .o_data  (w_cur)
  );

  // Current search step: shift by k only if the top k bits are clear and the
  // exponent stays >= 1, so the net shift is min(lzc, exp-1).
  assign w_k         = step_width(r_step);
  assign w_top_clear = (w_cur[23:0] & top_mask(w_k)) == 24'd0;
  assign w_exp_gt    = r_exp > EXP_W'(w_k);
  assign w_exp_inc   = in_exp + EXP_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_sh        <= '0;
      r_step      <= '0;
      r_ovf       <= 1'b0;
      r_spec      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign     <= in_sign;
            r_sh       <= '0;
            r_step     <= '0;
            r_in_ready <= 1'b0;
            if (in_exp == EXP_ONES) begin
              r_spec      <= 1'b1;
              r_mant      <= in_mant;
              r_exp       <= in_exp;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else if (in_mant == '0) begin
              r_mant      <= '0;
              r_exp       <= '0;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else if (in_mant[24]) begin
              r_exp <= w_exp_inc;
              if (w_exp_inc == EXP_ONES) begin
                r_mant <= '0;
                r_ovf  <= 1'b1;
              end else begin
                r_mant <= in_mant >> 1;
              end
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_mant  <= in_mant;
              r_exp   <= in_exp;
              r_state <= ST_STEP;
            end
          end
        end

        ST_STEP: begin
          if (w_top_clear && w_exp_gt) begin
            r_sh  <= r_sh | w_k;
            r_exp <= r_exp - EXP_W'(w_k);
          end
          r_step <= r_step + 3'd1;
          if (r_step == LAST_STEP) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            r_ovf       <= 1'b0;
            r_spec      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Exponent decode; a carry into the hidden bit from a denormal sum is promoted to exp 1.
  always_comb begin
    w_exp_dec = '0;
    if (r_ovf) begin
      w_exp_dec = EXP_ONES;
    end else if (r_spec) begin
      w_exp_dec = r_exp;
    end else if (w_cur[23]) begin
      w_exp_dec = (r_exp == '0) ? EXP_ONE : r_exp;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_sign   = r_out_valid & r_sign;
  assign out_exp    = r_out_valid ? w_exp_dec : '0;
  assign out_mant   = r_out_valid ? w_cur[23:0] : 24'd0;
  assign out_ovf    = r_out_valid & r_ovf;
  assign out_zero   = r_out_valid & !r_spec & !r_ovf & (w_cur == 25'd0);
  assign out_denorm = r_out_valid & !r_spec & !w_cur[23] & (w_cur != 25'd0);

endmodule

// File: tb/tb_fp_norm_ctrl.sv
// Scoreboard bench for fp_norm_ctrl: directed operands with hand-computed results.
module tb_fp_norm_ctrl;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        ovf;
    logic        zero;
    logic        den;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_ovf;
  logic        out_zero;
  logic        out_denorm;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_v = 1'b0;
  exp_t sb[$];

  fp_norm_ctrl #(.EXP_W(8), .MANT_W(25), .EXP_MAX(255)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_mant(out_mant), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_denorm(out_denorm)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic s, input logic [7:0] e, input logic [23:0] m,
                              input logic o, input logic z, input logic d, input int l);
    exp_t r;
    r.sign = s; r.exp = e; r.mant = m; r.ovf = o; r.zero = z; r.den = d; r.lat = l;
    return r;
  endfunction

  // Monitor: compare whenever a result is presented, pop on handshake.
  always @(negedge clk) begin
    exp_t     e;
    logic [35:0] act;
    logic [35:0] req;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: exp=%0d mant=%h with empty scoreboard", out_exp, out_mant);
        end else begin
          e   = sb[0];
          act = {out_sign, out_exp, out_mant, out_ovf, out_zero, out_denorm};
          req = {e.sign, e.exp, e.mant, e.ovf, e.zero, e.den};
          checks++;
          if (act !== req) begin
            errors++;
            $display("FAIL result: got sign=%b exp=%0d mant=%h ovf=%b zero=%b den=%b, want sign=%b exp=%0d mant=%h ovf=%b zero=%b den=%b",
                     out_sign, out_exp, out_mant, out_ovf, out_zero, out_denorm,
                     e.sign, e.exp, e.mant, e.ovf, e.zero, e.den);
          end
          if (!prev_v) begin
            checks++;
            if (cyc - acc_cyc != e.lat) begin
              errors++;
              $display("FAIL latency: got %0d clocks, want %0d", cyc - acc_cyc, e.lat);
            end
          end
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_in_done: got %b, want 0", in_ready);
          end
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_v = out_valid;
    end
    cyc++;
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                      input bit push, input exp_t ex);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got %b, want 1", in_ready);
    end else begin
      if (push) sb.push_back(ex);
      in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_exp !== 8'd0 || out_mant !== 24'd0 ||
        out_sign !== 1'b0 || out_ovf !== 1'b0 || out_zero !== 1'b0 || out_denorm !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b ready=%b exp=%0d mant=%h flags=%b%b%b sign=%b, want valid=0 ready=1 all zero",
               out_valid, in_ready, out_exp, out_mant, out_ovf, out_zero, out_denorm, out_sign);
    end

    // Normal path
    send(1'b0, 8'd100, 25'h0800000, 1'b1, mk(1'b0, 8'd100, 24'h800000, 1'b0, 1'b0, 1'b0, 6));
    send(1'b0, 8'd100, 25'h0000001, 1'b1, mk(1'b0, 8'd77,  24'h800000, 1'b0, 1'b0, 1'b0, 6));
    send(1'b1, 8'd20,  25'h0012345, 1'b1, mk(1'b1, 8'd13,  24'h91A280, 1'b0, 1'b0, 1'b0, 6));
    // Carry-out and exponent overflow
    send(1'b0, 8'd100, 25'h1000000, 1'b1, mk(1'b0, 8'd101, 24'h800000, 1'b0, 1'b0, 1'b0, 1));
    send(1'b1, 8'd254, 25'h1000000, 1'b1, mk(1'b1, 8'd255, 24'h000000, 1'b1, 1'b0, 1'b0, 1));
    // Underflow clamp to denormal, denormal carry promotion
    send(1'b0, 8'd5,   25'h0000100, 1'b1, mk(1'b0, 8'd0,   24'h001000, 1'b0, 1'b0, 1'b1, 6));
    send(1'b0, 8'd1,   25'h0400000, 1'b1, mk(1'b0, 8'd0,   24'h400000, 1'b0, 1'b0, 1'b1, 6));
    send(1'b0, 8'd0,   25'h0800000, 1'b1, mk(1'b0, 8'd1,   24'h800000, 1'b0, 1'b0, 1'b0, 6));
    // Zero and special
    send(1'b1, 8'd77,  25'h0000000, 1'b1, mk(1'b1, 8'd0,   24'h000000, 1'b0, 1'b1, 1'b0, 1));
    send(1'b0, 8'd255, 25'h0400000, 1'b1, mk(1'b0, 8'd255, 24'h400000, 1'b0, 1'b0, 1'b0, 1));
    drain();

    // Back-pressure: result held while out_ready low, new inputs ignored
    out_ready = 1'b0;
    send(1'b0, 8'd100, 25'h0000001, 1'b1, mk(1'b0, 8'd77, 24'h800000, 1'b0, 1'b0, 1'b0, 6));
    repeat (6) @(posedge clk);
    #1;
    in_valid = 1'b1; in_exp = 8'd255; in_mant = 25'h1FFFFFF; in_sign = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of the search drops the op
    send(1'b0, 8'd100, 25'h0000001, 1'b0, mk(1'b0, 8'd0, 24'h0, 1'b0, 1'b0, 1'b0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_step: got valid=%b ready=%b, want valid=0 ready=1", out_valid, in_ready);
    end
    send(1'b1, 8'd100, 25'h0800000, 1'b1, mk(1'b1, 8'd100, 24'h800000, 1'b0, 1'b0, 1'b0, 6));
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
